// File: rtl/spi_xip_pkg.sv
// Shared types and constants for the APB-attached SPI flash execute-in-place reader.
package spi_xip_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StDone
    } state_e;

    localparam logic [2:0] CsrDivOff     = 3'h0;
    localparam logic [2:0] CsrCfgOff     = 3'h4;
    localparam logic [7:0] DefaultOpcode = 8'h03;

    localparam int unsigned CmdBits  = 8;
    localparam int unsigned AddrBits = 24;
    localparam int unsigned DataBits = 32;

endpackage

// File: rtl/spi_flash_xip_apb_if.sv
// APB slave bus bundle for the SPI flash reader.
interface spi_flash_xip_apb_if;

    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_penable;
    logic [2:0]  in_pprot;
    logic        in_pwrite;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;

    modport master (
        output in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
        input  in_pready, in_prdata, in_pslverr
    );

    modport slave (
        input  in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
        output in_pready, in_prdata, in_pslverr
    );

endinterface

// File: rtl/spi_xip_shifter.sv
// SPI mode-0 bit engine: clock divider, sck generation, bit counter and a 32-bit shift pair.
// Shifts nbits bits continuously after start; MOSI refills with ones once the TX word drains.
module spi_xip_shifter #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [6:0]           nbits,
    input  logic [31:0]          tx_data,
    input  logic                 miso,
    output logic                 sck,
    output logic                 mosi,
    output logic [6:0]           bit_cnt,
    output logic                 bit_end,
    output logic [31:0]          rx_data
);

    logic                 busy_q;
    logic                 sck_q;
    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic [6:0]           bit_cnt_q;
    logic [31:0]          tx_q;
    logic [31:0]          rx_q;
    logic                 tick;

    assign tick    = busy_q && (div_cnt_q == div);
    assign bit_end = tick && sck_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            sck_q     <= 1'b0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '1;
            rx_q      <= '0;
        end else if (start) begin
            busy_q    <= 1'b1;
            sck_q     <= 1'b0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= tx_data;
        end else if (busy_q) begin
            if (tick) begin
                div_cnt_q <= '0;
                sck_q     <= ~sck_q;
                if (!sck_q) begin
                    // Sample on the same edge that raises sck.
                    rx_q <= {rx_q[30:0], miso};
                end else begin
                    tx_q      <= {tx_q[30:0], 1'b1};
                    bit_cnt_q <= bit_cnt_q + 7'd1;
                    if (bit_cnt_q == nbits - 7'd1) begin
                        busy_q <= 1'b0;
                    end
                end
            end else begin
                div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
            end
        end
    end

    assign sck     = sck_q;
    assign mosi    = tx_q[31];
    assign bit_cnt = bit_cnt_q;
    assign rx_data = rx_q;

endmodule

// File: rtl/spi_flash_xip_apb.sv
// APB slave mapping a read-only SPI flash window plus DIV/CFG control registers.
// Each flash read issues opcode, 24-bit word address, optional dummy bits and 32 data bits.
module spi_flash_xip_apb
    import spi_xip_pkg::*;
#(
    parameter logic [31:0]          FLASH_BASE  = 32'h3000_0000,
    parameter logic [31:0]          FLASH_END   = 32'h3fff_ffff,
    parameter logic [31:0]          CSR_BASE    = 32'h1000_1000,
    parameter int unsigned          SS_NUM      = 8,
    parameter int unsigned          DIV_WIDTH   = 8,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_flash_xip_apb_if.slave       apb,
    output logic                     spi_sck,
    output logic [SS_NUM-1:0]        spi_ss,
    output logic                     spi_mosi,
    input  logic                     spi_miso,
    output logic                     spi_irq_out
);

    state_e               state_q;
    logic [DIV_WIDTH-1:0] div_q, cap_div_q;
    logic [7:0]           cfg_opcode_q;
    logic [3:0]           cfg_dummy_q, cap_dummy_q;
    logic [2:0]           cfg_ss_q;
    logic [31:0]          cap_tx_q;
    logic                 start_q;
    logic                 pready_q;
    logic [31:0]          prdata_q;
    logic [SS_NUM-1:0]    ss_q;

    logic        access, in_flash, in_csr, ss_ok, csr_acc, err, flash_go, cfg_sel;
    logic [31:0] csr_rdata;
    logic [6:0]  nbits, bit_cnt;
    logic        bit_end;
    logic [31:0] rx_data;
    logic        unused_apb;

    assign unused_apb = ^{apb.in_pprot, apb.in_pstrb, apb.in_pwdata};

    // Bus decode is only live while idle; the bus cannot start a new access mid-read.
    assign access   = apb.in_psel && apb.in_penable && (state_q == StIdle);
    assign in_flash = (apb.in_paddr >= FLASH_BASE) && (apb.in_paddr <= FLASH_END);
    assign in_csr   = (apb.in_paddr[31:3] == CSR_BASE[31:3]);
    assign ss_ok    = 32'(cfg_ss_q) < SS_NUM;
    assign cfg_sel  = ({apb.in_paddr[2], 2'b00} == CsrCfgOff);
    assign csr_acc  = access && in_csr;
    assign err      = access && !in_csr && (!in_flash || apb.in_pwrite || !ss_ok);
    assign flash_go = access && !in_csr && in_flash && !apb.in_pwrite && ss_ok;

    always_comb begin
        csr_rdata = '0;
        if (cfg_sel) begin
            csr_rdata = {17'b0, cfg_ss_q, cfg_dummy_q, cfg_opcode_q};
        end else if ({apb.in_paddr[2], 2'b00} == CsrDivOff) begin
            csr_rdata = 32'(div_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= DEFAULT_DIV;
            cfg_opcode_q <= DefaultOpcode;
            cfg_dummy_q  <= '0;
            cfg_ss_q     <= '0;
        end else if (csr_acc && apb.in_pwrite) begin
            if (cfg_sel) begin
                cfg_opcode_q <= apb.in_pwdata[7:0];
                cfg_dummy_q  <= apb.in_pwdata[11:8];
                cfg_ss_q     <= apb.in_pwdata[14:12];
            end else begin
                div_q <= apb.in_pwdata[DIV_WIDTH-1:0];
            end
        end
    end

    assign nbits = 7'(CmdBits + AddrBits + DataBits) + 7'(cap_dummy_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ss_q        <= '1;
            start_q     <= 1'b0;
            pready_q    <= 1'b0;
            prdata_q    <= '0;
            cap_tx_q    <= '0;
            cap_div_q   <= '0;
            cap_dummy_q <= '0;
        end else begin
            start_q  <= 1'b0;
            pready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    prdata_q <= '0;
                    if (flash_go) begin
                        state_q     <= StCmd;
                        ss_q        <= ~(SS_NUM'(1) << cfg_ss_q);
                        start_q     <= 1'b1;
                        cap_tx_q    <= {cfg_opcode_q, apb.in_paddr[23:2], 2'b00};
                        cap_div_q   <= div_q;
                        cap_dummy_q <= cfg_dummy_q;
                    end
                end
                StCmd: begin
                    if (bit_end && bit_cnt == 7'(CmdBits - 1)) begin
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    if (bit_end && bit_cnt == 7'(CmdBits + AddrBits - 1)) begin
                        state_q <= (cap_dummy_q == 4'd0) ? StData : StDummy;
                    end
                end
                StDummy: begin
                    if (bit_end && bit_cnt == 7'(CmdBits + AddrBits - 1) + 7'(cap_dummy_q)) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (bit_end && bit_cnt == nbits - 7'd1) begin
                        state_q  <= StDone;
                        ss_q     <= '1;
                        pready_q <= 1'b1;
                        // First byte on the wire lands in the low byte of the word.
                        prdata_q <= {rx_data[7:0], rx_data[15:8], rx_data[23:16], rx_data[31:24]};
                    end
                end
                StDone: begin
                    state_q  <= StIdle;
                    prdata_q <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    spi_xip_shifter #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .start   (start_q),
        .div     (cap_div_q),
        .nbits   (nbits),
        .tx_data (cap_tx_q),
        .miso    (spi_miso),
        .sck     (spi_sck),
        .mosi    (spi_mosi),
        .bit_cnt (bit_cnt),
        .bit_end (bit_end),
        .rx_data (rx_data)
    );

    assign apb.in_pready  = pready_q | csr_acc | err;
    assign apb.in_pslverr = err;
    assign apb.in_prdata  = prdata_q | ((csr_acc && !apb.in_pwrite) ? csr_rdata : 32'h0);
    assign spi_ss         = ss_q;
    assign spi_irq_out    = 1'b0;

endmodule

// File: doc/spi_flash_xip_apb.md
SPI_FLASH_XIP_APB -- requirements
Module: spi_flash_xip_apb

Interface
REQ-001 SHALL have parameter FLASH_BASE, default 32'h30000000, meaning the first byte address of the flash read window.
REQ-002 SHALL have parameter FLASH_END, default 32'h3fffffff, meaning the last byte address of the flash read window.
REQ-003 SHALL have parameter CSR_BASE, default 32'h10001000, meaning the base of the 8-byte control register window.
REQ-004 SHALL have parameter SS_NUM, default 8, meaning the number of active-low slave selects (1..8).
REQ-005 SHALL have parameter DIV_WIDTH, default 8, meaning the clock-divider register width.
REQ-006 SHALL have parameter DEFAULT_DIV, default 0, meaning the reset value of DIV.
REQ-007 SHALL have ports clk in 1 (clock) and rst in 1 (reset); one clock, reset synchronous, active-high.
REQ-008 SHALL have APB slave ports: in_paddr in 32, in_psel in 1, in_penable in 1, in_pprot in 3 (ignored), in_pwrite in 1, in_pwdata in 32, in_pstrb in 4 (ignored), in_pready out 1, in_prdata out 32, in_pslverr out 1.
REQ-009 SHALL have SPI ports: spi_sck out 1, spi_ss out SS_NUM (active-low), spi_mosi out 1, spi_miso in 1, spi_irq_out out 1 (tied 0).

Function
REQ-010 Registers: DIV at CSR_BASE+0 (bits [DIV_WIDTH-1:0], reset DEFAULT_DIV); CFG at CSR_BASE+4 ([7:0] opcode reset 8'h03, [11:8] dummy bit count reset 0, [14:12] ss index reset 0); unused bits read 0.
REQ-011 CSR access: in_pready=1 in the first access-phase cycle (psel&penable), full-word write, read returns register value, in_pslverr=0.
REQ-012 Flash write, or access outside both windows, or ss index >= SS_NUM: in_pready=1 and in_pslverr=1 in the first access-phase cycle, no SPI activity, in_prdata=0.
REQ-013 Flash read FSM: IDLE -> CMD(8 bits opcode) -> ADDR(24 bits {in_paddr[23:2],2'b00}) -> DUMMY(CFG dummy bits, skipped if 0) -> DATA(32 bits) -> DONE -> IDLE.
REQ-014 Access-phase cycle T in IDLE: capture address/config; T+1 selected spi_ss bit low, state CMD.
REQ-015 SPI mode 0, MSB first: each bit = 2*(DIV+1) clk cycles, first half spi_sck=0 with spi_mosi valid, second half spi_sck=1; spi_miso sampled on the clk edge where spi_sck goes 0->1.
REQ-016 spi_mosi=1 during DUMMY, DATA and idle.
REQ-017 DONE lasts one cycle: spi_ss all ones, spi_sck=0, in_pready=1, in_pslverr=0, in_prdata valid.
REQ-018 Latency: in_pready asserts exactly 2 + N*2*(DIV+1) cycles after T, N = 64 + dummy (DIV=0, dummy=0 -> 130).
REQ-019 Byte order: flash bytes b0..b3 (received in order) SHALL return as in_prdata = {b3,b2,b1,b0}.
REQ-020 in_pready=0 in every cycle of a flash read other than DONE; DIV/CFG changes cannot occur mid-transfer (APB serial) and captured values are used regardless.
REQ-021 Outside DONE and error/CSR responses, in_pslverr=0 and in_prdata=0.

Reset
REQ-022 On rst=1 at a clk edge: state IDLE, spi_ss all ones, spi_sck=0, spi_mosi=1, in_pready=0, in_pslverr=0, in_prdata=0, DIV/CFG to reset values.
REQ-023 Reset mid-transfer SHALL abort immediately with the REQ-022 values in the next cycle; no in_pready for the aborted access.

Structure
REQ-024 Package spi_xip_pkg SHALL hold the FSM state enum, CSR offsets (0, 4), default opcode 8'h03, and phase bit counts (8, 24, 32).
REQ-025 One sub-module spi_xip_shifter SHALL implement divider, sck generation, bit counter and shift-in/out register; the top holds APB decode, CSRs and FSM.

Verification
REQ-026 Read 0x30000004, DIV=0, flash model bytes 11,22,33,44 at 0x000004 -> MOSI 03 000004, in_prdata=32'h44332211, pready at T+130.
REQ-027 Write CFG=32'h0000_080B, DIV=3, read 0x30000100 -> opcode 0x0B, 8 dummy bits, sck half-period 4 clk, pready at T+2+72*8=T+578.
REQ-028 Write to 0x30000000 and read 0x20000000 -> pready=1, pslverr=1 in first access cycle, spi_ss stays all ones.
REQ-029 CFG ss index 2 with SS_NUM=8 -> only spi_ss[2] low during transfer; index 7 with SS_NUM=4 -> pslverr=1.
REQ-030 Assert rst 40 cycles into a read -> next cycle ss all ones, sck=0, no pready; subsequent read completes correctly.
